pla_toggle_monitor: RTL and testbench

- Sequential activity monitor placed directly downstream of the 9-input/1-output max46 PLA benchmark logic in the power-aware synthesis flow.
- Each cycle it consumes one applied input vector (v0..v8) together with the resulting output v9.0.
- It counts input and output bit toggles between consecutive accepted samples over a programmable window.
- At window end it emits one switching-activity report over a valid/ready handshake; the RL power-cost estimator consumes that report.

---
 rtl/pla_mon_pkg.sv | 47 ++++
 rtl/pla_popcount.sv | 36 +++
 rtl/pla_toggle_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_pla_toggle_monitor.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_mon_pkg.sv
// -----------------------------------------------------------------------------
// pla_mon_pkg
//
// Shared definitions for the PLA toggle monitor:
//   - mon_state_t : monitor FSM states (EMPTY, ACCUM, REPORT)
//   - N_IN_DEF    : default width of the monitored PLA input vector (v0..v8)
//   - HD_W        : width of a single-sample Hamming distance for N_IN_DEF
//   - SAT_W       : operand width of the generic saturating adder
//   - sat_add()   : saturating add clamped to a caller-chosen counter width
//
// Optional feature macro used by the monitor: PLA_MON_PEAK_EN.
// -----------------------------------------------------------------------------
package pla_mon_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,   // no baseline sample held yet
      ACCUM  = 2'd1,   // baseline held, accumulating toggles
      REPORT = 2'd2    // report presented, waiting for the consumer
   } mon_state_t;

   localparam int N_IN_DEF = 9;
   localparam int HD_W     = $clog2(N_IN_DEF + 1);

   // Counters of any width up to SAT_W bits share one adder description.
   localparam int SAT_W = 32;

   // Returns a + b, clamped to the all-ones value of a w-bit counter.
   // The sum is formed one bit wider than the operands so a carry out of
   // SAT_W bits is also caught as an overflow.
   function automatic logic [SAT_W-1:0] sat_add(
      input logic [SAT_W-1:0] a,
      input logic [SAT_W-1:0] b,
      input int unsigned      w
   );
      logic [SAT_W:0] one;
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      one = (SAT_W + 1)'(1);
      sum = {1'b0, a} + {1'b0, b};
      lim = (one << w) - one;
      if (sum > lim) begin
         return lim[SAT_W-1:0];
      end
      return sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/pla_popcount.sv
// -----------------------------------------------------------------------------
// pla_popcount
//
// Purely combinational population count. The monitor feeds it the XOR of
// the current and previous PLA input vectors, so the result is the
// Hamming distance between consecutive samples.
//
// Parameters:
//   N_IN : width of the input vector
//   CW   : width of the count output; must hold the value N_IN
//
// Ports:
//   vec  in   N_IN  vector whose set bits are counted
//   cnt  out  CW    number of set bits in vec
// -----------------------------------------------------------------------------
module pla_popcount
   import pla_mon_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int CW   = HD_W
) (
   input  logic [N_IN-1:0] vec,
   output logic [CW-1:0]   cnt
);

   // NOTE: every variable written in an always_comb gets a value before any
   // conditional or loop touches it; otherwise a path that skips the write
   // would have to remember the old value and a latch would be inferred.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < N_IN; i++) begin
         cnt = cnt + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/pla_toggle_monitor.sv
// -----------------------------------------------------------------------------
// pla_toggle_monitor
//
// Switching-activity monitor placed downstream of the 9-input / 1-output
// max46 PLA. Every accepted sample is an applied input vector together
// with the PLA output it produced. Between consecutive accepted samples the
// monitor accumulates
//   - input toggles  : Hamming distance between successive input vectors
//   - output toggles : number of changes of the PLA output
//   - samples        : number of samples accepted in the window
// When WINDOW samples have been accepted, or when flush asks for an early
// report of a partial window, the totals are presented on a valid/ready
// report channel for the power-cost estimator.
//
// The very first sample after reset only establishes the baseline; it counts
// as a sample but contributes no toggles. After a report handshake the
// baseline is kept, so the next window's first sample is diffed against the
// last sample of the previous window.
//
// Parameters:
//   N_IN   : width of the monitored input vector
//   WINDOW : samples per report window, 2 .. 2**CNT_W-1
//   CNT_W  : width of every report counter
//
// Ports:
//   clk              in   1      clock, rising edge
//   rst              in   1      synchronous active-high reset
//   in_valid         in   1      sample present on in_vec / in_y
//   in_ready         out  1      monitor can accept a sample
//   in_vec           in   N_IN   PLA input vector, bit i = v_i
//   in_y             in   1      PLA output for in_vec
//   flush            in   1      request an early report of a partial window
//   rpt_valid        out  1      report fields valid and held stable
//   rpt_ready        in   1      consumer accepts the report
//   rpt_in_toggles   out  CNT_W  summed input Hamming distance of the window
//   rpt_out_toggles  out  CNT_W  output toggles of the window
//   rpt_samples      out  CNT_W  samples accepted in the window
//   rpt_peak         out  4      (PLA_MON_PEAK_EN only) largest single-sample
//                                input Hamming distance of the window
//
// Optional feature macro: PLA_MON_PEAK_EN. When it is not defined the
// rpt_peak port and its tracking registers do not exist.
// -----------------------------------------------------------------------------
module pla_toggle_monitor
   import pla_mon_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int WINDOW = 256,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_vec,
   input  logic             in_y,
   input  logic             flush,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_in_toggles,
   output logic [CNT_W-1:0] rpt_out_toggles,
   output logic [CNT_W-1:0] rpt_samples
`ifdef PLA_MON_PEAK_EN
   ,
   output logic [3:0]       rpt_peak
`endif
);

   localparam int               PC_W    = $clog2(N_IN + 1);
   localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

   mon_state_t       state;

   // Baseline: the most recently accepted sample.
   logic [N_IN-1:0]  prev_vec;
   logic             prev_y;

   // Running window totals and their values after the current cycle.
   logic [CNT_W-1:0] in_tog;
   logic [CNT_W-1:0] out_tog;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] in_tog_nxt;
   logic [CNT_W-1:0] out_tog_nxt;
   logic [CNT_W-1:0] sample_cnt_nxt;

   logic [PC_W-1:0]  hd;
   logic             accept;
   logic             accum_take;
   logic             go_report;

`ifdef PLA_MON_PEAK_EN
   logic [3:0]       peak;
   logic [3:0]       peak_nxt;
`endif

   pla_popcount #(
      .N_IN (N_IN),
      .CW   (PC_W)
   ) u_popcount (
      .vec (in_vec ^ prev_vec),
      .cnt (hd)
   );

   // Decoded straight from the state register so that a sample offered in
   // the first cycle after reset is taken; forced low while rst is held.
   assign in_ready   = !rst && (state != REPORT);
   assign accept     = in_valid && in_ready;
   assign accum_take = accept && (state == ACCUM);

   // Window totals including the sample accepted this cycle, if any.
   always_comb begin
      in_tog_nxt     = in_tog;
      out_tog_nxt    = out_tog;
      sample_cnt_nxt = sample_cnt;
      if (accum_take) begin
         in_tog_nxt     = CNT_W'(sat_add(SAT_W'(in_tog), SAT_W'(hd), CNT_W));
         out_tog_nxt    = CNT_W'(sat_add(SAT_W'(out_tog), SAT_W'(in_y ^ prev_y), CNT_W));
         sample_cnt_nxt = sample_cnt + CNT_W'(1);
      end
   end

`ifdef PLA_MON_PEAK_EN
   always_comb begin
      peak_nxt = peak;
      if (accum_take && (4'(hd) > peak)) begin
         peak_nxt = 4'(hd);
      end
   end
`endif

   // A sample that arrives together with flush is counted before the
   // report is cut. Window end and flush in the same cycle share this one
   // condition, so only a single report results.
   assign go_report = (state == ACCUM) &&
                      ((accum_take && (sample_cnt_nxt == WIN_CNT)) ||
                       (flush && (sample_cnt_nxt != '0)));

   // NOTE: state registers are written only with non-blocking assignments so
   // every register samples the pre-edge values of all the others, exactly
   // like the flip-flops they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= EMPTY;
         prev_vec        <= '0;
         prev_y          <= 1'b0;
         in_tog          <= '0;
         out_tog         <= '0;
         sample_cnt      <= '0;
         rpt_valid       <= 1'b0;
         rpt_in_toggles  <= '0;
         rpt_out_toggles <= '0;
         rpt_samples     <= '0;
`ifdef PLA_MON_PEAK_EN
         peak            <= '0;
         rpt_peak        <= '0;
`endif
      end else begin
         unique case (state)
            EMPTY: begin
               // First sample only sets the baseline; flush has no effect.
               if (accept) begin
                  prev_vec   <= in_vec;
                  prev_y     <= in_y;
                  sample_cnt <= CNT_W'(1);
                  state      <= ACCUM;
               end
            end

            ACCUM: begin
               in_tog     <= in_tog_nxt;
               out_tog    <= out_tog_nxt;
               sample_cnt <= sample_cnt_nxt;
`ifdef PLA_MON_PEAK_EN
               peak       <= peak_nxt;
`endif
               if (accept) begin
                  prev_vec <= in_vec;
                  prev_y   <= in_y;
               end
               if (go_report) begin
                  state           <= REPORT;
                  rpt_valid       <= 1'b1;
                  rpt_in_toggles  <= in_tog_nxt;
                  rpt_out_toggles <= out_tog_nxt;
                  rpt_samples     <= sample_cnt_nxt;
`ifdef PLA_MON_PEAK_EN
                  rpt_peak        <= peak_nxt;
`endif
               end
            end

            REPORT: begin
               // Report fields hold until the consumer takes them. The
               // baseline is deliberately left untouched.
               if (rpt_ready) begin
                  state           <= ACCUM;
                  rpt_valid       <= 1'b0;
                  in_tog          <= '0;
                  out_tog         <= '0;
                  sample_cnt      <= '0;
                  rpt_in_toggles  <= '0;
                  rpt_out_toggles <= '0;
                  rpt_samples     <= '0;
`ifdef PLA_MON_PEAK_EN
                  peak            <= '0;
                  rpt_peak        <= '0;
`endif
               end
            end

            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pla_toggle_monitor.sv
// -----------------------------------------------------------------------------
// tb_pla_toggle_monitor
//
// Self-checking bench for pla_toggle_monitor. Instance dut uses the default
// parameters (WINDOW=256, CNT_W=16); instance dut_s uses WINDOW=2, CNT_W=4
// to reach counter saturation quickly. The reference model tracks the
// window as plain integers: whether a baseline exists, the previous sample,
// unbounded toggle sums (clamped only when a report is formed) and whether
// a report is outstanding. Define PLA_MON_PEAK_EN to also check rpt_peak.
// -----------------------------------------------------------------------------
module tb_pla_toggle_monitor;

   localparam int WIN     = 256;
   localparam int CNT_MAX = 65535;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [8:0]  in_vec = '0;
   logic        in_y = 1'b0;
   logic        flush = 1'b0;
   logic        rpt_valid;
   logic        rpt_ready = 1'b0;
   logic [15:0] rpt_in_toggles;
   logic [15:0] rpt_out_toggles;
   logic [15:0] rpt_samples;
   logic [3:0]  rpt_peak;

   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [8:0]  s_in_vec = '0;
   logic        s_in_y = 1'b0;
   logic        s_flush = 1'b0;
   logic        s_rpt_valid;
   logic        s_rpt_ready = 1'b0;
   logic [3:0]  s_rpt_in;
   logic [3:0]  s_rpt_out;
   logic [3:0]  s_rpt_samples;
   logic [3:0]  s_rpt_peak;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pla_toggle_monitor #(.N_IN(9), .WINDOW(WIN), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_vec          (in_vec),
      .in_y            (in_y),
      .flush           (flush),
      .rpt_valid       (rpt_valid),
      .rpt_ready       (rpt_ready),
      .rpt_in_toggles  (rpt_in_toggles),
      .rpt_out_toggles (rpt_out_toggles),
      .rpt_samples     (rpt_samples)
`ifdef PLA_MON_PEAK_EN
      ,
      .rpt_peak        (rpt_peak)
`endif
   );

   pla_toggle_monitor #(.N_IN(9), .WINDOW(2), .CNT_W(4)) dut_s (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (s_in_valid),
      .in_ready        (s_in_ready),
      .in_vec          (s_in_vec),
      .in_y            (s_in_y),
      .flush           (s_flush),
      .rpt_valid       (s_rpt_valid),
      .rpt_ready       (s_rpt_ready),
      .rpt_in_toggles  (s_rpt_in),
      .rpt_out_toggles (s_rpt_out),
      .rpt_samples     (s_rpt_samples)
`ifdef PLA_MON_PEAK_EN
      ,
      .rpt_peak        (s_rpt_peak)
`endif
   );

`ifndef PLA_MON_PEAK_EN
   assign rpt_peak   = '0;
   assign s_rpt_peak = '0;
`endif

   // ---------------- reference model (main instance) ----------------
   bit         m_base;      // a baseline sample exists
   bit         m_pending;   // a report is outstanding
   logic [8:0] m_prev_vec;
   bit         m_prev_y;
   int         m_samples, m_in, m_out, m_peak;
   int         e_samples, e_in, e_out, e_peak;   // expected report fields

   function automatic int clamp(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic model_reset();
      m_base = 0; m_pending = 0; m_prev_vec = '0; m_prev_y = 0;
      m_samples = 0; m_in = 0; m_out = 0; m_peak = 0;
      e_samples = 0; e_in = 0; e_out = 0; e_peak = 0;
   endtask

   task automatic model_step(input bit v, input logic [8:0] vec, input bit y,
                             input bit fl, input bit rr);
      int d;
      if (m_pending) begin
         if (rr) begin
            m_pending = 0;
            m_samples = 0; m_in = 0; m_out = 0; m_peak = 0;
            e_samples = 0; e_in = 0; e_out = 0; e_peak = 0;
         end
      end else if (!m_base) begin
         if (v) begin
            m_base = 1; m_prev_vec = vec; m_prev_y = y; m_samples = 1;
         end
      end else begin
         if (v) begin
            d = $countones(vec ^ m_prev_vec);
            m_in += d;
            m_out += (y != m_prev_y) ? 1 : 0;
            m_samples++;
            if (d > m_peak) m_peak = d;
            m_prev_vec = vec; m_prev_y = y;
         end
         if ((v && m_samples == WIN) || (fl && m_samples > 0)) begin
            m_pending = 1;
            e_samples = m_samples; e_in = clamp(m_in);
            e_out = clamp(m_out); e_peak = m_peak;
         end
      end
   endtask

   // Drive one cycle on the main instance; outputs are looked at 1 time unit
   // after the edge, when the task returns.
   task automatic drive(input bit v, input logic [8:0] vec, input bit y,
                        input bit fl, input bit rr);
      in_valid = v; in_vec = vec; in_y = y; flush = fl; rpt_ready = rr;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(v, vec, y, fl, rr);
      #1;
      in_valid = 1'b0; flush = 1'b0; rpt_ready = 1'b0;
      in_vec = 9'($urandom); in_y = 1'($urandom);
   endtask

   task automatic s_drive(input bit v, input logic [8:0] vec, input bit y, input bit rr);
      s_in_valid = v; s_in_vec = vec; s_in_y = y; s_rpt_ready = rr;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0; s_rpt_ready = 1'b0;
      s_in_vec = 9'($urandom); s_in_y = 1'($urandom);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive(0, '0, 0, 0, 0);
      drive(0, '0, 0, 0, 0);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(1, 9'h1AB, 1, 1, 1);
      drive(1, 9'h055, 0, 1, 1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
      checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_rpt_valid got=%0b exp=0", rpt_valid); end
      checks++; if ({rpt_in_toggles, rpt_out_toggles, rpt_samples} !== 48'h0) begin
         errors++; $display("FAIL reset_fields got=%0d/%0d/%0d exp=0/0/0", rpt_in_toggles, rpt_out_toggles, rpt_samples);
      end
      checks++; if (rpt_peak !== 4'h0) begin errors++; $display("FAIL reset_peak got=%0d exp=0", rpt_peak); end
      checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_s_in_ready got=%0b exp=0", s_in_ready); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_full_window();
      logic [8:0] v;
      for (int i = 0; i < WIN; i++) begin
         v = i[0] ? 9'h1FF : 9'h000;
         drive(1, v, ^v, 0, 0);
         if (i == WIN - 2) begin
            checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL early_rpt_valid got=%0b exp=0", rpt_valid); end
         end
      end
      checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL window_rpt_valid got=%0b exp=1", rpt_valid); end
      checks++; if (rpt_samples !== 16'd256) begin errors++; $display("FAIL window_samples got=%0d exp=256", rpt_samples); end
      checks++; if (rpt_in_toggles !== 16'd2295) begin errors++; $display("FAIL window_in_tog got=%0d exp=2295", rpt_in_toggles); end
      checks++; if (rpt_out_toggles !== 16'd255) begin errors++; $display("FAIL window_out_tog got=%0d exp=255", rpt_out_toggles); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL window_in_ready got=%0b exp=0", in_ready); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 20; i++) begin
         drive(1, 9'($urandom), 1'($urandom), 0, 0);
         checks++;
         if (in_ready !== 1'b0 || rpt_valid !== 1'b1 || rpt_samples !== 16'd256 ||
             rpt_in_toggles !== 16'd2295 || rpt_out_toggles !== 16'd255) begin
            errors++;
            $display("FAIL hold_cycle%0d got rdy=%0b vld=%0b %0d/%0d/%0d exp rdy=0 vld=1 256/2295/255",
                     i, in_ready, rpt_valid, rpt_samples, rpt_in_toggles, rpt_out_toggles);
         end
      end
      drive(0, '0, 0, 0, 1);
      checks++; if (rpt_valid !== 1'b0 || in_ready !== 1'b1 || rpt_samples !== 16'd0) begin
         errors++; $display("FAIL handshake got vld=%0b rdy=%0b smp=%0d exp vld=0 rdy=1 smp=0", rpt_valid, in_ready, rpt_samples);
      end
      drive(1, 9'h000, 0, 0, 0);
      drive(0, '0, 0, 1, 0);
      checks++; if (rpt_valid !== 1'b1 || rpt_samples !== 16'd1 || rpt_in_toggles !== 16'd9 || rpt_out_toggles !== 16'd1) begin
         errors++; $display("FAIL baseline_kept got vld=%0b %0d/%0d/%0d exp vld=1 1/9/1",
                            rpt_valid, rpt_samples, rpt_in_toggles, rpt_out_toggles);
      end
      drive(0, '0, 0, 0, 1);
   endtask

   task automatic test_flush();
      logic [8:0] seq [5] = '{9'h000, 9'h001, 9'h003, 9'h007, 9'h00F};
      for (int i = 0; i < 5; i++) drive(1, seq[i], 0, (i == 4), 0);
      checks++; if (rpt_valid !== 1'b1 || rpt_samples !== 16'd5 || rpt_in_toggles !== 16'd4 || rpt_out_toggles !== 16'd0) begin
         errors++; $display("FAIL flush_report got vld=%0b %0d/%0d/%0d exp vld=1 5/4/0",
                            rpt_valid, rpt_samples, rpt_in_toggles, rpt_out_toggles);
      end
`ifdef PLA_MON_PEAK_EN
      checks++; if (rpt_peak !== 4'd1) begin errors++; $display("FAIL flush_peak got=%0d exp=1", rpt_peak); end
`endif
      drive(0, '0, 0, 0, 1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < WIN; i++) drive(1, 9'($urandom), 1'($urandom), (i == WIN - 1), 0);
      checks++; if (rpt_valid !== 1'b1 || rpt_samples !== 16'(e_samples) ||
                    rpt_in_toggles !== 16'(e_in) || rpt_out_toggles !== 16'(e_out)) begin
         errors++; $display("FAIL end_and_flush got vld=%0b %0d/%0d/%0d exp vld=1 %0d/%0d/%0d",
                            rpt_valid, rpt_samples, rpt_in_toggles, rpt_out_toggles, e_samples, e_in, e_out);
      end
      drive(0, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, '0, 0, 0, 0);
         checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL double_report cycle%0d got=%0b exp=0", i, rpt_valid); end
      end
   endtask

   task automatic test_reset_during_report();
      drive(1, 9'h0AA, 0, 0, 0);
      drive(0, '0, 0, 1, 0);
      checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_report got=%0b exp=1", rpt_valid); end
      rst = 1'b1;
      drive(0, '0, 0, 0, 0);
      checks++; if (rpt_valid !== 1'b0 || {rpt_in_toggles, rpt_out_toggles, rpt_samples} !== 48'h0) begin
         errors++; $display("FAIL mid_reset got vld=%0b %0d/%0d/%0d exp vld=0 0/0/0",
                            rpt_valid, rpt_samples, rpt_in_toggles, rpt_out_toggles);
      end
      rst = 1'b0;
      drive(1, 9'h1FF, 1, 0, 0);
      drive(1, 9'h000, 0, 0, 0);
      drive(1, 9'h1FF, 1, 0, 0);
      drive(0, '0, 0, 1, 0);
      checks++; if (rpt_valid !== 1'b1 || rpt_samples !== 16'd3 || rpt_in_toggles !== 16'd18 || rpt_out_toggles !== 16'd2) begin
         errors++; $display("FAIL post_reset_window got vld=%0b %0d/%0d/%0d exp vld=1 3/18/2",
                            rpt_valid, rpt_samples, rpt_in_toggles, rpt_out_toggles);
      end
   endtask

   task automatic test_ignored_flush();
      // Report from the previous test is still outstanding.
      for (int i = 0; i < 3; i++) begin
         drive(1, 9'($urandom), 1, 1, 0);
         checks++; if (rpt_valid !== 1'b1 || rpt_samples !== 16'd3 || rpt_in_toggles !== 16'd18) begin
            errors++; $display("FAIL flush_in_report got vld=%0b smp=%0d in=%0d exp vld=1 smp=3 in=18",
                               rpt_valid, rpt_samples, rpt_in_toggles);
         end
      end
      drive(0, '0, 0, 0, 1);
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, '0, 0, 1, 0);
         checks++; if (rpt_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_in_empty got vld=%0b rdy=%0b exp vld=0 rdy=1", rpt_valid, in_ready);
         end
      end
      drive(1, 9'h123, 1, 1, 0);
      checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL flush_with_baseline got=%0b exp=0", rpt_valid); end
      drive(0, '0, 0, 1, 0);
      checks++; if (rpt_valid !== 1'b1 || rpt_samples !== 16'd1 || rpt_in_toggles !== 16'd0) begin
         errors++; $display("FAIL baseline_only_report got vld=%0b smp=%0d in=%0d exp vld=1 smp=1 in=0",
                            rpt_valid, rpt_samples, rpt_in_toggles);
      end
      drive(0, '0, 0, 0, 1);
      drive(0, '0, 0, 1, 0);
      checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL flush_zero_count got=%0b exp=0", rpt_valid); end
   endtask

   task automatic test_random();
      bit exp_rdy;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 499) == 0);
         drive($urandom_range(0, 3) != 0, 9'($urandom), 1'($urandom),
               $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
         exp_rdy = !rst && !m_pending;
         checks++;
         if (rpt_valid !== m_pending || in_ready !== exp_rdy || rpt_samples !== 16'(e_samples) ||
             rpt_in_toggles !== 16'(e_in) || rpt_out_toggles !== 16'(e_out)) begin
            errors++;
            $display("FAIL random_cycle%0d got vld=%0b rdy=%0b %0d/%0d/%0d exp vld=%0b rdy=%0b %0d/%0d/%0d",
                     n, rpt_valid, in_ready, rpt_samples, rpt_in_toggles, rpt_out_toggles,
                     m_pending, exp_rdy, e_samples, e_in, e_out);
         end
`ifdef PLA_MON_PEAK_EN
         checks++; if (rpt_peak !== 4'(e_peak)) begin
            errors++; $display("FAIL random_peak cycle%0d got=%0d exp=%0d", n, rpt_peak, e_peak);
         end
`endif
      end
      rst = 1'b0;
   endtask

   task automatic test_saturation();
      s_drive(1, 9'h1FF, 1, 0);
      s_drive(1, 9'h000, 0, 0);
      checks++; if (s_rpt_valid !== 1'b1 || s_rpt_samples !== 4'd2 || s_rpt_in !== 4'd9 || s_rpt_out !== 4'd1) begin
         errors++; $display("FAIL small_window1 got vld=%0b %0d/%0d/%0d exp vld=1 2/9/1",
                            s_rpt_valid, s_rpt_samples, s_rpt_in, s_rpt_out);
      end
`ifdef PLA_MON_PEAK_EN
      checks++; if (s_rpt_peak !== 4'd9) begin errors++; $display("FAIL small_peak got=%0d exp=9", s_rpt_peak); end
`endif
      s_drive(0, '0, 0, 1);
      checks++; if (s_rpt_valid !== 1'b0) begin errors++; $display("FAIL small_handshake got=%0b exp=0", s_rpt_valid); end
      s_drive(1, 9'h1FF, 1, 0);
      s_drive(1, 9'h000, 0, 0);
      checks++; if (s_rpt_valid !== 1'b1 || s_rpt_samples !== 4'd2 || s_rpt_in !== 4'hF || s_rpt_out !== 4'd2) begin
         errors++; $display("FAIL small_saturate got vld=%0b %0d/%0d/%0d exp vld=1 2/15/2",
                            s_rpt_valid, s_rpt_samples, s_rpt_in, s_rpt_out);
      end
      s_drive(0, '0, 0, 1);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_window();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_reset_during_report();
      test_ignored_flush();
      test_random();
      apply_reset();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
